load_store_writeback: RTL and testbench

- Multi-cycle memory access and writeback stage for the RISC-V core.
- Accepts one load/store command, performs a handshaked access to data memory, then formats load data.
- Drives the register file write port (A3/WD3/WE3) directly; the register file's write side is fed only by this block for memory ops.
- Stores complete without touching the register file.

---
 rtl/load_store_writeback.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_writeback.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_writeback.sv
// Memory access and writeback stage: runs one load/store as a handshaked data-memory
// access. Loads are formatted and written to the register file; stores finish quietly.
module load_store_writeback #(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic            IsStore,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] Addr,
    input  logic [XLEN-1:0] StoreData,
    input  logic [4:0]      Rd,
    output logic            Busy,
    output logic            Done,
    output logic            Err,
    output logic            MemReq,
    output logic            MemWe,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWData,
    output logic [3:0]      MemByteEn,
    input  logic            MemAck,
    input  logic [XLEN-1:0] MemRData,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3,
    output logic            WE3
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WB,
        FIN
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;

    logic            cmd_legal;
    logic            cmd_misaligned;
    logic [3:0]      cmd_be;
    logic [XLEN-1:0] cmd_wdata;
    logic [XLEN-1:0] load_data;

    // Funct3[1:0] encodes the access size (00 byte, 01 half, 10 word); bit 2 is "unsigned".
    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0]      f3,
                                                 input logic [1:0]      off,
                                                 input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        case (Funct3)
            3'b000, 3'b001, 3'b010: cmd_legal = 1'b1;
            3'b100, 3'b101:         cmd_legal = !IsStore;
            default:                cmd_legal = 1'b0;
        endcase

        cmd_misaligned = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                         ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));

        case (Funct3[1:0])
            2'b00:   cmd_be = 4'b0001 << Addr[1:0];
            2'b01:   cmd_be = Addr[1] ? 4'b1100 : 4'b0011;
            default: cmd_be = 4'b1111;
        endcase

        // Replicating the store data puts the right bytes on every enabled lane.
        if (!IsStore) begin
            cmd_wdata = '0;
        end else begin
            case (Funct3[1:0])
                2'b00:   cmd_wdata = {4{StoreData[7:0]}};
                2'b01:   cmd_wdata = {2{StoreData[15:0]}};
                default: cmd_wdata = StoreData;
            endcase
        end

        load_data = fmt_load(funct3_q, off_q, MemRData);
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        a3_d        = a3_q;
        wd3_d       = wd3_q;

        Busy   = (state_q != IDLE);
        MemReq = (state_q == REQ);
        MemWe  = (state_q == REQ) && is_store_q;
        Done   = (state_q == WB) || (state_q == FIN);
        WE3    = (state_q == WB) && (rd_q != 5'd0);
        Err    = err_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (!cmd_legal || cmd_misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        is_store_d  = IsStore;
                        funct3_d    = Funct3;
                        off_d       = Addr[1:0];
                        rd_d        = Rd;
                        mem_addr_d  = {Addr[XLEN-1:2], 2'b00};
                        mem_wdata_d = cmd_wdata;
                        mem_be_d    = cmd_be;
                        cnt_d       = 8'd0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (MemAck) begin
                    cnt_d = 8'd0;
                    if (is_store_q) begin
                        state_d = FIN;
                    end else begin
                        state_d = WB;
                        // x0 is never written, so the write port keeps its previous values.
                        if (rd_q != 5'd0) begin
                            a3_d  = rd_q;
                            wd3_d = load_data;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WB:      state_d = IDLE;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'd0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            a3_q        <= 5'd0;
            wd3_q       <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
        end
    end

    assign MemAddr   = mem_addr_q;
    assign MemWData  = mem_wdata_q;
    assign MemByteEn = mem_be_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;

endmodule

// File: tb/tb_load_store_writeback.sv
// Self-checking bench for load_store_writeback: a memory responder drives each command,
// and expected transaction outcomes queued at drive time are compared when it completes.
module tb_load_store_writeback;

    localparam int TMO = 4;

    logic        Clk, Rst, Start, IsStore;
    logic [2:0]  Funct3;
    logic [31:0] Addr, StoreData;
    logic [4:0]  Rd;
    logic        Busy, Done, Err, MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic        MemAck;
    logic [31:0] MemRData;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;

    load_store_writeback #(.TIMEOUT(TMO), .XLEN(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .IsStore(IsStore), .Funct3(Funct3),
        .Addr(Addr), .StoreData(StoreData), .Rd(Rd), .Busy(Busy), .Done(Done),
        .Err(Err), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemByteEn(MemByteEn), .MemAck(MemAck),
        .MemRData(MemRData), .A3(A3), .WD3(WD3), .WE3(WE3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0]  req_cycles;
        logic        memwe;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic        stable;
    } mem_side_t;

    typedef struct packed {
        logic [1:0]  done_cnt;
        logic [1:0]  we3_cnt;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic [7:0]  latency;
    } wb_side_t;

    typedef struct packed {
        logic err;
        logic busy_at_err;
        logic both;
        logic done_after;
        logic err_after;
        logic timed_out;
    } st_side_t;

    typedef struct {
        mem_side_t m;
        wb_side_t  w;
        st_side_t  s;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  last_a3  = 5'd0;
    logic [31:0] last_wd3 = 32'd0;

    function automatic txn_t exp_ok(input logic st, input logic [3:0] be,
                                    input logic [31:0] maddr, input logic [31:0] wdata,
                                    input int k, input logic [4:0] a3,
                                    input logic [31:0] wd3, input logic we);
        txn_t t;
        t.m = '{req_cycles: 8'(k + 1), memwe: st, be: be, maddr: maddr, wdata: wdata,
                stable: 1'b1};
        t.w = '{done_cnt: 2'd1, we3_cnt: (we ? 2'd1 : 2'd0), a3: a3, wd3: wd3,
                latency: 8'(k + 1)};
        t.s = '0;
        return t;
    endfunction

    function automatic txn_t exp_err();
        txn_t t;
        t.m = '0;
        t.m.stable = 1'b1;
        t.w = '0;
        t.s = '0;
        t.s.err = 1'b1;
        return t;
    endfunction

    // Drives one command at the current negedge, plays the memory, and records what it saw.
    // Returns one negedge after Done/Err, which is the earliest back-to-back Start slot.
    task automatic run_cmd(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] rd, input int ack_k,
                           input logic [31:0] rdata, input bit poke);
        txn_t o;
        int   req_n;
        int   first_req;
        bit   fin;
        o.m = '0;
        o.m.stable = 1'b1;
        o.w = '0;
        o.s = '0;
        req_n = 0;
        first_req = 0;
        fin = 1'b0;
        Start = 1'b1; IsStore = st; Funct3 = f3; Addr = addr; StoreData = sdata; Rd = rd;
        @(negedge Clk);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            if (cyc > 0) @(negedge Clk);
            Start  = 1'b0;
            MemAck = 1'b0;
            if (MemReq) begin
                if (req_n == 0) begin
                    first_req = cyc;
                    o.m.memwe = MemWe; o.m.be = MemByteEn;
                    o.m.maddr = MemAddr; o.m.wdata = MemWData;
                end else if ({MemWe, MemByteEn, MemAddr, MemWData} !==
                             {o.m.memwe, o.m.be, o.m.maddr, o.m.wdata}) begin
                    o.m.stable = 1'b0;
                end
                if (req_n == ack_k) begin
                    MemAck = 1'b1;
                    MemRData = rdata;
                end else begin
                    MemRData = ~rdata;
                end
                if (poke) begin
                    Start = 1'b1; Funct3 = 3'b011; Addr = ~addr;
                end
                req_n++;
            end
            if (WE3) o.w.we3_cnt = o.w.we3_cnt + 2'd1;
            if (Done && Err) o.s.both = 1'b1;
            if (Done) begin
                o.w.done_cnt = o.w.done_cnt + 2'd1;
                o.w.a3 = A3;
                o.w.wd3 = WD3;
                o.w.latency = 8'(cyc - first_req);
                fin = 1'b1;
            end
            if (Err) begin
                o.s.err = 1'b1;
                o.s.busy_at_err = Busy;
                fin = 1'b1;
            end
        end
        if (!fin) o.s.timed_out = 1'b1;
        o.m.req_cycles = 8'(req_n);
        @(negedge Clk);
        Start  = 1'b0;
        MemAck = 1'b0;
        o.s.done_after = Done;
        o.s.err_after  = Err;
        if (WE3) o.w.we3_cnt = o.w.we3_cnt + 2'd1;
        obs_q.push_back(o);
    endtask

    task automatic load_case(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                             input int k, input logic [31:0] rdata, input logic [3:0] be,
                             input logic [31:0] wd3);
        if (rd != 5'd0) begin
            exp_q.push_back(exp_ok(1'b0, be, {addr[31:2], 2'b00}, 32'd0, k, rd, wd3, 1'b1));
            last_a3 = rd;
            last_wd3 = wd3;
        end else begin
            exp_q.push_back(exp_ok(1'b0, be, {addr[31:2], 2'b00}, 32'd0, k, last_a3, last_wd3,
                                   1'b0));
        end
        run_cmd(1'b0, f3, addr, 32'hA5A5_5A5A, rd, k, rdata, 1'b0);
    endtask

    task automatic store_case(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input int k, input logic [3:0] be,
                              input logic [31:0] wdata, input bit poke);
        exp_q.push_back(exp_ok(1'b1, be, {addr[31:2], 2'b00}, wdata, k, last_a3, last_wd3, 1'b0));
        run_cmd(1'b1, f3, addr, sdata, 5'd17, k, 32'hFFFF_FFFF, poke);
    endtask

    task automatic err_case(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        exp_q.push_back(exp_err());
        run_cmd(st, f3, addr, 32'h5555_AAAA, 5'd3, 0, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_reset;
        n_checks++;
        if ({Busy, Done, Err, MemReq, MemWe, WE3, MemByteEn, A3, MemAddr, MemWData, WD3} !== '0)
        begin
            n_fail++;
            $display("FAIL reset_state: got %b_%b_%b_%b_%b_%b be=%h a3=%h ma=%h wd=%h wd3=%h want all 0",
                     Busy, Done, Err, MemReq, MemWe, WE3, MemByteEn, A3, MemAddr, MemWData, WD3);
        end
    endtask

    task automatic test_loads;
        txn_t e, o;
        load_case(3'b010, 32'h100, 5'd5, 1, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        load_case(3'b000, 32'h103, 5'd6, 0, 32'h80FF_FF12, 4'b1000, 32'hFFFF_FF80);
        load_case(3'b100, 32'h103, 5'd7, 2, 32'h80FF_FF12, 4'b1000, 32'h0000_0080);
        load_case(3'b101, 32'h102, 5'd8, 0, 32'h80FF_FF12, 4'b1100, 32'h0000_80FF);
        load_case(3'b001, 32'h102, 5'd9, 3, 32'h80FF_FF12, 4'b1100, 32'hFFFF_80FF);
        load_case(3'b000, 32'h100, 5'd10, 1, 32'h80FF_FF12, 4'b0001, 32'h0000_0012);
        load_case(3'b101, 32'h100, 5'd11, 0, 32'h80FF_FF92, 4'b0011, 32'h0000_FF92);
        load_case(3'b001, 32'h100, 5'd12, 0, 32'h1234_8001, 4'b0011, 32'hFFFF_8001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks += 3;
            if (o.m !== e.m) begin n_fail++; $display("FAIL load%0d_mem: got %h want %h", i, o.m, e.m); end
            if (o.w !== e.w) begin n_fail++; $display("FAIL load%0d_wb: got %h want %h", i, o.w, e.w); end
            if (o.s !== e.s) begin n_fail++; $display("FAIL load%0d_status: got %b want %b", i, o.s, e.s); end
        end
    endtask

    task automatic test_stores;
        txn_t e, o;
        store_case(3'b000, 32'h201, 32'h1234_56AB, 0, 4'b0010, 32'hABAB_ABAB, 1'b0);
        store_case(3'b001, 32'h202, 32'hCAFE_1234, 1, 4'b1100, 32'h1234_1234, 1'b0);
        store_case(3'b010, 32'h204, 32'h8765_4321, 3, 4'b1111, 32'h8765_4321, 1'b1);
        store_case(3'b000, 32'h20F, 32'h0000_00C3, 2, 4'b1000, 32'hC3C3_C3C3, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks += 3;
            if (o.m !== e.m) begin n_fail++; $display("FAIL store%0d_mem: got %h want %h", i, o.m, e.m); end
            if (o.w !== e.w) begin n_fail++; $display("FAIL store%0d_wb: got %h want %h", i, o.w, e.w); end
            if (o.s !== e.s) begin n_fail++; $display("FAIL store%0d_status: got %b want %b", i, o.s, e.s); end
        end
    endtask

    task automatic test_errors;
        txn_t e, o;
        err_case(1'b0, 3'b001, 32'h101);
        err_case(1'b0, 3'b010, 32'h102);
        err_case(1'b0, 3'b011, 32'h100);
        err_case(1'b1, 3'b100, 32'h100);
        err_case(1'b1, 3'b010, 32'h206);
        err_case(1'b1, 3'b001, 32'h203);
        load_case(3'b010, 32'h108, 5'd0, 1, 32'h0F0F_0F0F, 4'b1111, 32'h0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks += 3;
            if (o.m !== e.m) begin n_fail++; $display("FAIL err%0d_mem: got %h want %h", i, o.m, e.m); end
            if (o.w !== e.w) begin n_fail++; $display("FAIL err%0d_wb: got %h want %h", i, o.w, e.w); end
            if (o.s !== e.s) begin n_fail++; $display("FAIL err%0d_status: got %b want %b", i, o.s, e.s); end
        end
    endtask

    task automatic test_timeout;
        txn_t e, o;
        e = exp_err();
        e.m = '{req_cycles: 8'(TMO), memwe: 1'b0, be: 4'b1111, maddr: 32'h400, wdata: 32'd0,
                stable: 1'b1};
        exp_q.push_back(e);
        run_cmd(1'b0, 3'b010, 32'h400, 32'd0, 5'd13, -1, 32'd0, 1'b0);
        load_case(3'b010, 32'h404, 5'd14, TMO - 1, 32'h7654_3210, 4'b1111, 32'h7654_3210);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks += 3;
            if (o.m !== e.m) begin n_fail++; $display("FAIL tmo%0d_mem: got %h want %h", i, o.m, e.m); end
            if (o.w !== e.w) begin n_fail++; $display("FAIL tmo%0d_wb: got %h want %h", i, o.w, e.w); end
            if (o.s !== e.s) begin n_fail++; $display("FAIL tmo%0d_status: got %b want %b", i, o.s, e.s); end
        end
    endtask

    task automatic test_back_to_back;
        txn_t e, o;
        load_case(3'b100, 32'h501, 5'd20, 0, 32'h0000_9A00, 4'b0010, 32'h0000_009A);
        store_case(3'b001, 32'h500, 32'h0000_BEEF, 0, 4'b0011, 32'hBEEF_BEEF, 1'b0);
        err_case(1'b0, 3'b110, 32'h500);
        load_case(3'b000, 32'h502, 5'd21, 0, 32'h0071_0000, 4'b0100, 32'h0000_0071);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks += 3;
            if (o.m !== e.m) begin n_fail++; $display("FAIL b2b%0d_mem: got %h want %h", i, o.m, e.m); end
            if (o.w !== e.w) begin n_fail++; $display("FAIL b2b%0d_wb: got %h want %h", i, o.w, e.w); end
            if (o.s !== e.s) begin n_fail++; $display("FAIL b2b%0d_status: got %b want %b", i, o.s, e.s); end
        end
    endtask

    task automatic test_reset_mid_req;
        txn_t e, o;
        Start = 1'b1; IsStore = 1'b0; Funct3 = 3'b010; Addr = 32'h300; Rd = 5'd7;
        @(negedge Clk);
        Start = 1'b0;
        n_checks++;
        if ({MemReq, Busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_pre_req: got req/busy %b want 11", {MemReq, Busy});
        end
        #2 Rst = 1'b1;
        #1;
        n_checks++;
        if ({MemReq, Busy, WE3, MemWe, Done, MemAddr, A3, WD3} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got req=%b busy=%b we3=%b we=%b done=%b ma=%h a3=%h wd3=%h want 0",
                     MemReq, Busy, WE3, MemWe, Done, MemAddr, A3, WD3);
        end
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        last_a3 = 5'd0;
        last_wd3 = 32'd0;
        load_case(3'b010, 32'h104, 5'd9, 2, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks += 3;
            if (o.m !== e.m) begin n_fail++; $display("FAIL rst%0d_mem: got %h want %h", i, o.m, e.m); end
            if (o.w !== e.w) begin n_fail++; $display("FAIL rst%0d_wb: got %h want %h", i, o.w, e.w); end
            if (o.s !== e.s) begin n_fail++; $display("FAIL rst%0d_status: got %b want %b", i, o.s, e.s); end
        end
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; IsStore = 1'b0; Funct3 = 3'd0; Addr = 32'd0;
        StoreData = 32'd0; Rd = 5'd0; MemAck = 1'b0; MemRData = 32'd0;
        repeat (3) @(negedge Clk);
        test_reset;
        Rst = 1'b0;
        @(negedge Clk);
        test_loads;
        test_stores;
        test_errors;
        test_timeout;
        test_back_to_back;
        test_reset_mid_req;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
